// File: rtl/mem_store_buffer_pkg.sv
// -----------------------------------------------------------------------------
// mem_store_buffer_pkg
// Shared types for the committed-store buffer: the buffer entry layout, the
// drain FSM state encoding and the byte-enable width derivation.
// Entry fields are sized from SB_ADDR_W / SB_DATA_W. The buffer's ADDR_W and
// DATA_W parameters may be equal to or narrower than these widths.
// -----------------------------------------------------------------------------
package mem_store_buffer_pkg;

    localparam int SB_ADDR_W = 64;
    localparam int SB_DATA_W = 64;
    localparam int SB_TAG_W  = SB_ADDR_W - 3;   // doubleword tag, byte offset dropped
    localparam int SB_STRB_W = SB_DATA_W / 8;

    function automatic int sb_strb_w(input int data_w);
        return data_w / 8;
    endfunction

    typedef struct packed {
        logic [SB_TAG_W-1:0]  tag;
        logic [SB_DATA_W-1:0] data;
        logic [SB_STRB_W-1:0] strb;
    } sb_entry_t;

    typedef enum logic [1:0] {
        SB_IDLE = 2'd0,
        SB_REQ  = 2'd1,
        SB_WAIT = 2'd2
    } sb_state_e;

endpackage

// File: rtl/mem_store_buffer_sb_fwd_merge.sv
// -----------------------------------------------------------------------------
// mem_store_buffer_sb_fwd_merge
// Byte-granular store-to-load forwarding. For every byte the load needs, the
// youngest valid entry with a matching tag and that byte enabled supplies it.
// Ports:
//   i_ent / i_vld   buffer entries and their valid bits
//   i_order         physical entry index, youngest first (i_order[0] = youngest)
//   i_ld_addr       load address (doubleword tag taken from bits above [2:0])
//   i_ld_strb       bytes the load needs
//   o_ld_hit        every needed byte is covered
//   o_ld_data       covered bytes, lane aligned; other lanes zero
//   o_ld_conflict   some but not all needed bytes are covered
// -----------------------------------------------------------------------------
module mem_store_buffer_sb_fwd_merge
    import mem_store_buffer_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = SB_ADDR_W,
    parameter  int DATA_W = SB_DATA_W,
    localparam int STRB_W = sb_strb_w(DATA_W),
    localparam int PTR_W  = $clog2(DEPTH)
)(
    input  sb_entry_t          i_ent   [DEPTH],
    input  logic [DEPTH-1:0]   i_vld,
    input  logic [PTR_W-1:0]   i_order [DEPTH],
    input  logic [ADDR_W-1:0]  i_ld_addr,
    input  logic [STRB_W-1:0]  i_ld_strb,
    output logic               o_ld_hit,
    output logic [DATA_W-1:0]  o_ld_data,
    output logic               o_ld_conflict
);

    logic [SB_TAG_W-1:0]  w_tag;
    logic [SB_STRB_W-1:0] w_need;
    logic [SB_STRB_W-1:0] w_cov;
    logic [SB_DATA_W-1:0] w_data;

    assign w_tag  = SB_TAG_W'(i_ld_addr >> 3);
    assign w_need = SB_STRB_W'(i_ld_strb);

    // Walk oldest to youngest so a younger entry overwrites an older one.
    always_comb begin
        w_cov  = '0;
        w_data = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (i_vld[i_order[k]] && (i_ent[i_order[k]].tag == w_tag)) begin
                for (int b = 0; b < SB_STRB_W; b++) begin
                    if (w_need[b] && i_ent[i_order[k]].strb[b]) begin
                        w_cov[b]          = 1'b1;
                        w_data[b*8 +: 8]  = i_ent[i_order[k]].data[b*8 +: 8];
                    end
                end
            end
        end
    end

    // w_cov is a subset of w_need, so equality means full coverage.
    assign o_ld_hit      = (w_cov != '0) && (w_cov == w_need);
    assign o_ld_conflict = (w_cov != '0) && (w_cov != w_need);
    assign o_ld_data     = DATA_W'(w_data);

endmodule

// File: rtl/mem_store_buffer.sv
// -----------------------------------------------------------------------------
// mem_store_buffer
// Committed-store buffer between the memory stage and the data bus. Retired
// stores are queued in a DEPTH-entry circular FIFO and written to memory one
// at a time in the background. Stores to the youngest entry's doubleword are
// coalesced, loads are forwarded byte by byte, and drain_req/empty support
// fence.i.
// Ports:
//   clock, reset (async, active-low)
//   st_valid/st_ready/st_addr/st_wdata/st_strb   store push interface
//   ld_addr/ld_strb -> ld_hit/ld_data/ld_conflict load forwarding lookup
//   drain_req -> empty                            flush handshake
//   bus_en/bus_addr/bus_wdata/bus_strb            head write request
//   bus_valid/bus_acc_err                         write completion
//   st_err/st_err_addr                            faulted-drain report
// -----------------------------------------------------------------------------
module mem_store_buffer
    import mem_store_buffer_pkg::*;
#(
    parameter  int DEPTH  = 4,
    parameter  int ADDR_W = SB_ADDR_W,
    parameter  int DATA_W = SB_DATA_W,
    localparam int STRB_W = sb_strb_w(DATA_W)
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              st_valid,
    output logic              st_ready,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_wdata,
    input  logic [STRB_W-1:0] st_strb,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [STRB_W-1:0] ld_strb,
    output logic              ld_hit,
    output logic [DATA_W-1:0] ld_data,
    output logic              ld_conflict,
    input  logic              drain_req,
    output logic              empty,
    output logic              bus_en,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [STRB_W-1:0] bus_strb,
    input  logic              bus_valid,
    input  logic              bus_acc_err,
    output logic              st_err,
    output logic [ADDR_W-1:0] st_err_addr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    sb_entry_t          r_ent [DEPTH];
    logic [DEPTH-1:0]   r_vld;
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [CNT_W-1:0]   r_count;
    sb_state_e          r_state;
    logic               r_st_err;
    logic [ADDR_W-1:0]  r_st_err_addr;

    sb_state_e            w_state_nxt;
    logic [PTR_W-1:0]     w_young;
    logic [PTR_W-1:0]     w_order [DEPTH];
    logic [SB_TAG_W-1:0]  w_st_tag;
    logic [SB_DATA_W-1:0] w_wdata;
    logic [SB_STRB_W-1:0] w_strb;
    sb_entry_t            w_merged;
    logic                 w_full;
    logic                 w_merge_ok;
    logic                 w_push;
    logic                 w_alloc;
    logic                 w_pop;
    logic [ADDR_W-1:0]    w_head_addr;

    assign w_young     = r_tail - PTR_W'(1);
    assign w_st_tag    = SB_TAG_W'(st_addr >> 3);
    assign w_wdata     = SB_DATA_W'(st_wdata);
    assign w_strb      = SB_STRB_W'(st_strb);
    assign w_head_addr = ADDR_W'({r_ent[r_head].tag, 3'b000});
    assign w_full      = (r_count == CNT_W'(DEPTH));

    // The head is in flight from REQ until its completion; while the youngest
    // entry is also the head it must not change under the bus.
    assign w_merge_ok = (r_count != '0) && r_vld[w_young] &&
                        (r_ent[w_young].tag == w_st_tag) &&
                        !((r_state != SB_IDLE) && (w_young == r_head));

    assign st_ready = !drain_req && (!w_full || w_merge_ok);
    assign w_push   = st_valid && st_ready;
    assign w_alloc  = w_push && !w_merge_ok;
    assign w_pop    = (r_state == SB_WAIT) && bus_valid;

    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            w_order[k] = r_tail - PTR_W'(1) - PTR_W'(k);
        end
    end

    always_comb begin
        w_merged = r_ent[w_young];
        for (int b = 0; b < SB_STRB_W; b++) begin
            if (w_strb[b]) begin
                w_merged.data[b*8 +: 8] = w_wdata[b*8 +: 8];
                w_merged.strb[b]        = 1'b1;
            end
        end
    end

    // Entry payload carries no reset; r_vld qualifies it.
    always_ff @(posedge clock) begin
        if (w_alloc) begin
            r_ent[r_tail] <= '{tag: w_st_tag, data: w_wdata, strb: w_strb};
        end else if (w_push) begin
            r_ent[w_young] <= w_merged;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
            r_vld         <= '0;
            r_state       <= SB_IDLE;
            r_st_err      <= 1'b0;
            r_st_err_addr <= '0;
        end else begin
            r_state <= w_state_nxt;
            // alloc and pop never target the same slot: alloc needs a free slot
            // and pop needs count > 0, so tail != head whenever both happen.
            if (w_alloc) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + PTR_W'(1);
            end
            r_count  <= r_count + CNT_W'(w_alloc) - CNT_W'(w_pop);
            r_st_err <= w_pop && bus_acc_err;
            if (w_pop && bus_acc_err) begin
                r_st_err_addr <= w_head_addr;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        bus_en      = 1'b0;
        case (r_state)
            SB_IDLE: begin
                if (r_count != '0) w_state_nxt = SB_REQ;
            end
            SB_REQ: begin
                bus_en      = 1'b1;
                w_state_nxt = SB_WAIT;
            end
            SB_WAIT: begin
                if (bus_valid) w_state_nxt = (r_count > CNT_W'(1)) ? SB_REQ : SB_IDLE;
            end
            default: w_state_nxt = SB_IDLE;
        endcase
    end

    // The head entry cannot change while in flight, so these hold through WAIT.
    assign bus_addr    = w_head_addr;
    assign bus_wdata   = DATA_W'(r_ent[r_head].data);
    assign bus_strb    = STRB_W'(r_ent[r_head].strb);
    assign empty       = (r_count == '0) && (r_state == SB_IDLE);
    assign st_err      = r_st_err;
    assign st_err_addr = r_st_err_addr;

    mem_store_buffer_sb_fwd_merge #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_fwd (
        .i_ent         (r_ent),
        .i_vld         (r_vld),
        .i_order       (w_order),
        .i_ld_addr     (ld_addr),
        .i_ld_strb     (ld_strb),
        .o_ld_hit      (ld_hit),
        .o_ld_data     (ld_data),
        .o_ld_conflict (ld_conflict)
    );

endmodule

// File: tb/tb_mem_store_buffer.sv
// -----------------------------------------------------------------------------
// tb_mem_store_buffer
// Directed scenarios followed by random traffic, checked every cycle against a
// queue-based reference of the store buffer.
// -----------------------------------------------------------------------------
module tb_mem_store_buffer;

    localparam int DEPTH = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        st_valid;
    logic        st_ready;
    logic [63:0] st_addr;
    logic [63:0] st_wdata;
    logic [7:0]  st_strb;
    logic [63:0] ld_addr;
    logic [7:0]  ld_strb;
    logic        ld_hit;
    logic [63:0] ld_data;
    logic        ld_conflict;
    logic        drain_req;
    logic        empty;
    logic        bus_en;
    logic [63:0] bus_addr;
    logic [63:0] bus_wdata;
    logic [7:0]  bus_strb;
    logic        bus_valid;
    logic        bus_acc_err;
    logic        st_err;
    logic [63:0] st_err_addr;

    always #5 clock = ~clock;

    mem_store_buffer #(.DEPTH(DEPTH), .ADDR_W(64), .DATA_W(64)) dut (
        .clock(clock), .reset(reset),
        .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
        .st_wdata(st_wdata), .st_strb(st_strb),
        .ld_addr(ld_addr), .ld_strb(ld_strb), .ld_hit(ld_hit),
        .ld_data(ld_data), .ld_conflict(ld_conflict),
        .drain_req(drain_req), .empty(empty),
        .bus_en(bus_en), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_strb(bus_strb), .bus_valid(bus_valid), .bus_acc_err(bus_acc_err),
        .st_err(st_err), .st_err_addr(st_err_addr)
    );

    typedef struct {
        logic [60:0] tag;
        logic [63:0] data;
        logic [7:0]  strb;
    } ment_t;

    ment_t       q[$];
    int          n_chk = 0;
    int          n_err = 0;
    bit          waiting = 0;
    int          lat_left = 0;
    int          fixed_lat = -1;
    bit          bus_hold = 0;
    bit          force_err = 0;
    bit          rand_err = 0;
    bit          exp_err = 0;
    logic [63:0] exp_err_addr = '0;
    int          idle_cnt = 0;
    int          n_bus_en = 0;
    logic        s_ready, s_empty, s_hit, s_conf, s_err, s_bus_en;
    logic [63:0] s_data, s_err_addr;

    task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model_ld(input logic [63:0] addr, input logic [7:0] need,
                                     output logic hit, output logic conf, output logic [63:0] data);
        logic [7:0] cov;
        cov  = '0;
        data = '0;
        for (int b = 0; b < 8; b++) begin
            if (need[b]) begin
                for (int i = q.size() - 1; i >= 0; i--) begin
                    if (q[i].tag == addr[63:3] && q[i].strb[b]) begin
                        cov[b] = 1'b1;
                        data[b*8 +: 8] = q[i].data[b*8 +: 8];
                        break;
                    end
                end
            end
        end
        hit  = (need != 0) && (cov == need);
        conf = (cov != 0) && (cov != need);
    endfunction

    // One clock: check at negedge, advance model at posedge, then act as the bus.
    task automatic step();
        logic        merge_ok, exp_ready, e_hit, e_conf, push, pop, en_now;
        logic [63:0] e_data;
        ment_t       e;
        @(negedge clock);
        s_ready = st_ready; s_empty = empty; s_hit = ld_hit; s_conf = ld_conflict;
        s_data = ld_data; s_err = st_err; s_err_addr = st_err_addr; s_bus_en = bus_en;
        en_now    = bus_en;
        merge_ok  = (q.size() > 0) && (q[q.size()-1].tag == st_addr[63:3]) &&
                    !((waiting || en_now) && q.size() == 1);
        exp_ready = !drain_req && ((q.size() < DEPTH) || merge_ok);
        chk_eq("st_ready", st_ready, exp_ready);
        chk_eq("empty", empty, q.size() == 0);
        model_ld(ld_addr, ld_strb, e_hit, e_conf, e_data);
        chk_eq("ld_hit", ld_hit, e_hit);
        chk_eq("ld_conflict", ld_conflict, e_conf);
        if (e_hit) chk_eq("ld_data", ld_data, e_data);
        chk_eq("st_err", st_err, exp_err);
        chk_eq("st_err_addr", st_err_addr, exp_err_addr);
        if (en_now) begin
            n_bus_en++;
            idle_cnt = 0;
            if (q.size() == 0 || waiting) begin
                chk_eq("bus_en_spurious", bus_en, 0);
            end else begin
                chk_eq("bus_addr", bus_addr, {q[0].tag, 3'b000});
                chk_eq("bus_wdata", bus_wdata, q[0].data);
                chk_eq("bus_strb", bus_strb, q[0].strb);
            end
        end else if (q.size() > 0 && !waiting) begin
            idle_cnt++;
            if (idle_cnt > 2) chk_eq("bus_en_late", bus_en, 1);
        end else begin
            idle_cnt = 0;
        end
        push = st_valid && exp_ready && reset;
        pop  = waiting && bus_valid && reset;
        @(posedge clock);
        exp_err = 0;
        if (reset) begin
            if (push) begin
                if (merge_ok) begin
                    e = q[q.size()-1];
                    for (int b = 0; b < 8; b++) begin
                        if (st_strb[b]) begin
                            e.data[b*8 +: 8] = st_wdata[b*8 +: 8];
                            e.strb[b] = 1'b1;
                        end
                    end
                    q[q.size()-1] = e;
                end else begin
                    e.tag = st_addr[63:3]; e.data = st_wdata; e.strb = st_strb;
                    q.push_back(e);
                end
            end
            if (pop) begin
                if (bus_acc_err) begin
                    exp_err = 1;
                    exp_err_addr = {q[0].tag, 3'b000};
                end
                void'(q.pop_front());
                waiting = 0;
            end
            if (en_now) begin
                waiting  = 1;
                lat_left = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
            end
        end
        #1;
        bus_valid = 1'b0;
        bus_acc_err = 1'b0;
        if (waiting && !bus_hold) begin
            if (lat_left == 0) begin
                bus_valid = 1'b1;
                bus_acc_err = force_err || (rand_err && ($urandom_range(0, 7) == 0));
            end else begin
                lat_left--;
            end
        end
    endtask

    task automatic push_st(input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
        st_valid = 1'b1; st_addr = a; st_wdata = d; st_strb = s;
        step();
        st_valid = 1'b0;
    endtask

    task automatic run_until_empty(input int budget);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(s_empty && q.size() == 0) && n < budget);
        chk_eq("drain_done", s_empty, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        reset = 1'b0; st_valid = 0; st_addr = '0; st_wdata = '0; st_strb = '0;
        ld_addr = '0; ld_strb = '0; drain_req = 0; bus_valid = 0; bus_acc_err = 0;
        step();
        chk_eq("rst_st_ready", s_ready, 1);
        chk_eq("rst_empty", s_empty, 1);
        chk_eq("rst_bus_en", s_bus_en, 0);
        chk_eq("rst_st_err_addr", s_err_addr, 0);
        reset = 1'b1;
        step();

        // single push, completion 3 cycles after bus_en
        fixed_lat = 2;
        n_bus_en = 0;
        push_st(64'h1000, 64'h11223344_55667788, 8'hFF);
        run_until_empty(30);
        chk_eq("single_bus_en_cnt", n_bus_en, 1);

        // coalesce behind a blocked head, then forward
        fixed_lat = -1;
        bus_hold = 1;
        push_st(64'h5000, 64'hDEAD_BEEF_0BAD_F00D, 8'hFF);
        push_st(64'h2000, 64'h00000000_AABBCCDD, 8'h0F);
        push_st(64'h2004, 64'h11223344_00000000, 8'hF0);
        ld_addr = 64'h2000; ld_strb = 8'hFF;
        step();
        chk_eq("fwd_hit", s_hit, 1);
        chk_eq("fwd_data", s_data, 64'h11223344_AABBCCDD);
        push_st(64'h3000, 64'h00000000_000000EE, 8'h01);
        ld_addr = 64'h3000; ld_strb = 8'h03;
        step();
        chk_eq("conf_conflict", s_conf, 1);
        chk_eq("conf_hit", s_hit, 0);
        ld_strb = 8'h00;

        // fill, full-but-merge, and slot reuse after a pop
        push_st(64'h6000, 64'h66666666_66666666, 8'hFF);
        st_valid = 1; st_addr = 64'h7000; st_wdata = 64'h7; st_strb = 8'hFF;
        step();
        chk_eq("full_ready", s_ready, 0);
        st_addr = 64'h6000; st_wdata = 64'h99; st_strb = 8'h01;
        step();
        chk_eq("full_merge_ready", s_ready, 1);
        st_valid = 0;
        bus_hold = 0;
        n = 0;
        while (q.size() >= DEPTH && n < 20) begin step(); n++; end
        st_valid = 1; st_addr = 64'h7000; st_wdata = 64'h7; st_strb = 8'hFF;
        step();
        chk_eq("after_pop_ready", s_ready, 1);
        st_valid = 0;
        run_until_empty(60);

        // access fault on the head
        fixed_lat = 1;
        force_err = 1;
        push_st(64'h4000, 64'h4444, 8'hFF);
        push_st(64'h4008, 64'h4448, 8'hFF);
        n = 0;
        do begin step(); n++; end while (!bus_valid && n < 20);
        force_err = 0;
        step();
        step();
        chk_eq("fault_st_err", s_err, 1);
        chk_eq("fault_err_addr", s_err_addr, 64'h4000);
        run_until_empty(30);

        // drain with three entries queued
        fixed_lat = -1;
        bus_hold = 1;
        push_st(64'h8000, 64'h80, 8'hFF);
        push_st(64'h8008, 64'h88, 8'hFF);
        push_st(64'h8010, 64'h90, 8'hFF);
        drain_req = 1; st_valid = 1; st_addr = 64'h8010; st_strb = 8'h01;
        bus_hold = 0;
        n = 0;
        do begin
            step();
            chk_eq("drain_blocks", s_ready, 0);
            n++;
        end while (!s_empty && n < 60);
        chk_eq("drain_empty", s_empty, 1);
        st_valid = 0;
        step();
        chk_eq("drain_idle_empty", s_empty, 1);
        drain_req = 0;

        // reset while an access is outstanding
        bus_hold = 1;
        push_st(64'hA000, 64'hA0A0, 8'hFF);
        n = 0;
        do begin step(); n++; end while (!s_bus_en && n < 20);
        chk_eq("wait_issue", s_bus_en, 1);
        step();
        reset = 1'b0;
        #1;
        chk_eq("arst_bus_en", bus_en, 0);
        chk_eq("arst_ready", st_ready, 1);
        chk_eq("arst_empty", empty, 1);
        chk_eq("arst_st_err", st_err, 0);
        chk_eq("arst_err_addr", st_err_addr, 0);
        chk_eq("arst_ld_hit", ld_hit, 0);
        q.delete(); waiting = 0; exp_err = 0; exp_err_addr = '0; idle_cnt = 0;
        step();
        reset = 1'b1;
        bus_hold = 0;
        bus_valid = 1; bus_acc_err = 1;
        step();
        repeat (3) step();
        chk_eq("late_valid_no_pop", s_empty, 1);

        // random traffic
        rand_err = 1;
        for (int c = 0; c < 3000; c++) begin
            st_valid  = $urandom_range(0, 1);
            st_addr   = 64'h1000 + 64'(8 * $urandom_range(0, 5)) + 64'($urandom_range(0, 7));
            st_wdata  = {$urandom, $urandom};
            st_strb   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
            ld_addr   = 64'h1000 + 64'(8 * $urandom_range(0, 5));
            ld_strb   = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
            drain_req = ($urandom_range(0, 9) == 0);
            bus_hold  = ($urandom_range(0, 7) == 0);
            step();
        end
        st_valid = 0; drain_req = 0; bus_hold = 0; rand_err = 0;
        run_until_empty(200);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/mem_store_buffer.md
Name: mem_store_buffer

Overview:
- Parametrised committed-store buffer between the memory stage and the data bus.
- Retired stores enter a DEPTH-entry FIFO and drain to memory in the background, so a store no longer stalls the pipeline for the whole bus round-trip.
- Adds what the single-access memory stage lacks: same-doubleword store coalescing, byte-granular store-to-load forwarding with conflict detection, and a drain/empty handshake for fence.i.

Parameters:
- DEPTH, 4, number of buffer entries; power of two, at least 2.
- ADDR_W, 64, address width in bits.
- DATA_W, 64, data width in bits; STRB_W = DATA_W/8.

Ports:
- clock  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- st_valid  in  1  committed store offered.
- st_ready  out  1  buffer can accept or merge the store.
- st_addr  in  ADDR_W  store byte address; bits [2:0] ignored (doubleword-aligned tag).
- st_wdata  in  DATA_W  lane-aligned store data.
- st_strb  in  STRB_W  byte enables; all-zero is legal and is a no-op push.
- ld_addr  in  ADDR_W  load address from the memory stage.
- ld_strb  in  STRB_W  bytes the load needs.
- ld_hit  out  1  all needed bytes are held in the buffer.
- ld_data  out  DATA_W  forwarded lane-aligned data; valid when ld_hit.
- ld_conflict  out  1  some but not all needed bytes are held; the memory stage must stall.
- drain_req  in  1  fence.i or flush request; blocks new pushes.
- empty  out  1  count==0 and no bus access outstanding.
- bus_en  out  1  one-cycle write request.
- bus_addr  out  ADDR_W  head address (doubleword-aligned).
- bus_wdata  out  DATA_W  head data.
- bus_strb  out  STRB_W  head byte enables.
- bus_valid  in  1  write completion.
- bus_acc_err  in  1  access fault, qualified by bus_valid.
- st_err  out  1  one-cycle pulse on a faulted drain.
- st_err_addr  out  ADDR_W  address of the faulted entry; holds its value until the next fault.

Behaviour:
- Reset (reset==0, asynchronous):
  - head, tail and count go to 0; drain FSM goes to IDLE; all entry valid bits cleared.
  - Outputs: st_ready=1, empty=1; bus_en, st_err, ld_hit and ld_conflict =0; st_err_addr=0.
  - Reset asserted mid-access discards the outstanding access; any bus_valid that arrives afterwards is ignored.
- Storage: circular FIFO of {addr tag, data, strb}; head and tail wrap modulo DEPTH; count ranges 0..DEPTH.
- Push or merge (on st_valid && st_ready at the clock edge):
  - Merge when count>0, the tag equals the youngest entry's tag, and the youngest entry is not the in-flight head. Per byte where st_strb=1: data byte is replaced and the strb bit is set. count is unchanged.
  - Otherwise allocate at tail; tail++, count++.
  - st_ready = !drain_req && (count<DEPTH || merge-eligible). A full buffer can still merge.
  - No same-cycle bypass: a pop frees a slot only from the next cycle.
- Load lookup (combinational, zero latency), per needed byte:
  - Select the youngest valid entry with a matching tag and its strb bit set.
  - The in-flight head is included until it is popped.
  - ld_hit = every needed byte is covered; ld_data assembles the covered bytes; unneeded lanes are 0.
  - ld_conflict = at least one needed byte is covered and at least one is not.
  - No coverage gives ld_hit=0 and ld_conflict=0; the load goes to the bus normally.
- Drain FSM:
  - IDLE: when count>0, go to REQ.
  - REQ: drive bus_en=1 for exactly one cycle, with addr/data/strb taken from the head; go to WAIT.
  - WAIT: bus_* outputs hold their values. On bus_valid, pop the head (head++, count--). If bus_acc_err, also pulse st_err and capture st_err_addr. Then go to REQ if count>1, else IDLE.
  - Back-to-back throughput is one store per 2 cycles plus bus latency.
- Simultaneous push and pop: count is unchanged and both pointers advance.
- Merge into the entry currently being popped is impossible by construction.
- Drain:
  - While drain_req=1, pushes are blocked and the FIFO drains normally.
  - empty=1 once count==0 and the FSM is in IDLE.
  - drain_req with an empty buffer gives empty=1 in the same cycle.
- A faulted store is dropped, not retried. Trap generation from st_err belongs to the consumer.

Decomposition:
- Shared package: sb_entry_t {addr tag, data, strb}, the drain FSM state enum, and the STRB_W derivation.
- One natural sub-module: sb_fwd_merge. It takes the entry array plus the youngest-first ordering and computes the per-byte ld_data, ld_hit and ld_conflict, which keeps the priority-select logic separately testable.

Test Plan:
- Single push: st 0x1000, data 0x11223344_55667788, strb 0xFF, bus_valid 3 cycles after bus_en → exactly one bus_en pulse with matching addr/data/strb; count returns to 0 and empty=1.
- Coalesce: strb 0x0F at 0x2000 (data ..AABBCCDD), then strb 0xF0 at 0x2004 (data 0x11223344_xxxxxxxx) while the head is blocked by another entry → count=2, and a single drain of 0x2000 with strb 0xFF and data 0x11223344_AABBCCDD.
- Forwarding:
  - Hit: after the coalesce above, a load of 0x2000 with ld_strb 0xFF → ld_hit=1 and ld_data=0x11223344_AABBCCDD.
  - Conflict: a fresh tag 0x3000 with strb 0x01, then a load with ld_strb 0x03 → ld_conflict=1, ld_hit=0.
- Full: DEPTH=4 with distinct tags and bus_valid held low → st_ready=0 after the 4th push. A 5th push to the youngest tag still merges (st_ready=1). After one bus_valid, st_ready=1 on the next cycle.
- Fault: bus_valid=1 with bus_acc_err=1 on the head 0x4000 → st_err pulses for 1 cycle, st_err_addr=0x4000, the entry is popped, and the next entry issues.
- Drain and reset:
  - drain_req with 3 entries queued → st_ready=0 until empty=1 after 3 completions.
  - reset dropped low while in WAIT → all outputs return to reset values immediately, and a late bus_valid causes no pop.
